// File: rtl/multi_freq_divider.sv
// multi_freq_divider: N-channel programmable clock divider.
//
// Each channel counts enabled clock_in edges up to its active half-period
// divisor, toggles its square-wave output and pulses tick at the terminal
// count. New divisors are first captured in a per-channel shadow register.
// They are copied into the active divisor only at a terminal count, while
// the channel is disabled, or on a phase-sync pulse. This way a half-period
// never ends early or runs long because of a mid-count write.
//
// Optional feature: define MULTI_FREQ_DIVIDER_PHASE_SYNC_EN to add the
// sync_in input. A pulse on sync_in restarts every channel from a low
// output with count 0, so all outputs become phase-aligned.
//
// Reset: clear_n is synchronous and active-low. It is sampled on the
// rising edge of clock_in.

module multi_freq_divider #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 25000000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              clear_n,
`ifdef MULTI_FREQ_DIVIDER_PHASE_SYNC_EN
    input  logic              sync_in,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] tick
);

    // Reset divisor, sized to the counter width.
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    // The channel count is widened by one bit so that it stays representable
    // when NUM_CH is an exact power of two.
    localparam logic [CH_W:0] NUM_CH_W = (CH_W + 1)'(NUM_CH);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [CNT_W-1:0]  r_div    [NUM_CH];
    logic [CNT_W-1:0]  r_shadow [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_clk;
    logic [NUM_CH-1:0] r_tick;
    logic              r_wr_ack;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  w_cnt_nxt    [NUM_CH];
    logic [CNT_W-1:0]  w_div_nxt    [NUM_CH];
    logic [CNT_W-1:0]  w_shadow_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_pending_nxt;
    logic [NUM_CH-1:0] w_clk_nxt;
    logic [NUM_CH-1:0] w_tick_nxt;
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_apply;
    logic              w_wr_valid;
    logic              w_sync;

`ifdef MULTI_FREQ_DIVIDER_PHASE_SYNC_EN
    assign w_sync = sync_in;
`else
    assign w_sync = 1'b0;
`endif

    // Decode the write port: a write is accepted only for an existing channel.
    always_comb begin
        w_wr_valid = 1'b0;
        w_wr_hit   = '0;
        if (wr_en && ({1'b0, wr_ch} < NUM_CH_W)) begin
            w_wr_valid = 1'b1;
        end else begin
            w_wr_valid = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_wr_valid && (wr_ch == CH_W'(i))) begin
                w_wr_hit[i] = 1'b1;
            end else begin
                w_wr_hit[i] = 1'b0;
            end
        end
    end

    // Per-channel counting, toggling, and shadow-divisor application.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_clk_nxt     = r_clk;
        w_tick_nxt    = r_tick;
        w_apply       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_sync) begin
                // Phase sync: restart every channel from a low output.
                w_cnt_nxt[i]  = '0;
                w_clk_nxt[i]  = 1'b0;
                w_tick_nxt[i] = 1'b0;
                w_apply[i]    = 1'b1;
            end else if (ch_en[i]) begin
                if (r_cnt[i] == r_div[i]) begin
                    // Terminal count: end of a half-period.
                    w_cnt_nxt[i]  = '0;
                    w_clk_nxt[i]  = ~r_clk[i];
                    w_tick_nxt[i] = 1'b1;
                    w_apply[i]    = 1'b1;
                end else begin
                    w_cnt_nxt[i]  = r_cnt[i] + CNT_W'(1);
                    w_tick_nxt[i] = 1'b0;
                    w_apply[i]    = 1'b0;
                end
            end else begin
                // Idle channel: the output holds and the count restarts on
                // re-enable. An idle channel can take a new divisor at once.
                w_cnt_nxt[i]  = '0;
                w_tick_nxt[i] = 1'b0;
                w_apply[i]    = 1'b1;
            end

            // Apply the shadow that was pending before this edge.
            if (w_apply[i] && r_pending[i]) begin
                w_div_nxt[i]     = r_shadow[i];
                w_pending_nxt[i] = 1'b0;
            end else begin
                w_div_nxt[i]     = r_div[i];
                w_pending_nxt[i] = r_pending[i];
            end

            // A write in the same cycle always lands in the shadow.
            // It overrides the pending clear above, so the new value waits
            // for the next apply point.
            if (w_wr_hit[i]) begin
                w_shadow_nxt[i]  = wr_data;
                w_pending_nxt[i] = 1'b1;
            end else begin
                w_shadow_nxt[i]  = r_shadow[i];
            end
        end
    end

    // Register all channel state; clear_n has priority over everything.
    always_ff @(posedge clock_in) begin
        if (!clear_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= '0;
                r_div[i]    <= DEF_DIV;
                r_shadow[i] <= DEF_DIV;
            end
            r_pending <= '0;
            r_clk     <= '0;
            r_tick    <= '0;
            r_wr_ack  <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_clk     <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
            r_wr_ack  <= w_wr_valid;
        end
    end

    assign wr_ack    = r_wr_ack;
    assign pending   = r_pending;
    assign clock_out = r_clk;
    assign tick      = r_tick;

endmodule

// File: tb/tb_multi_freq_divider.sv
// Testbench for multi_freq_divider.
//
// The bench runs three channels. With three channels, wr_ch is two bits
// wide and can address a channel that does not exist. It combines directed
// stimulus, which follows the bring-up scenarios, with a randomized soak.
// Every cycle, the outputs are compared against a behavioural model. The
// model keeps, for each channel, the number of enabled edges elapsed in the
// current half-period. A half-period ends after div+1 such edges.

module tb_multi_freq_divider;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 3;
    localparam int CH_W    = 2;

    logic              clock_in = 1'b0;
    logic              clear_n  = 1'b0;
    logic              sync_in  = 1'b0;
    logic [NUM_CH-1:0] ch_en    = '0;
    logic              wr_en    = 1'b0;
    logic [CH_W-1:0]   wr_ch    = '0;
    logic [CNT_W-1:0]  wr_data  = '0;
    logic              wr_ack;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] clock_out;
    logic [NUM_CH-1:0] tick;

    multi_freq_divider #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clock_in  (clock_in),
        .clear_n   (clear_n),
`ifdef MULTI_FREQ_DIVIDER_PHASE_SYNC_EN
        .sync_in   (sync_in),
`endif
        .ch_en     (ch_en),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .pending   (pending),
        .clock_out (clock_out),
        .tick      (tick)
    );

    always #5 clock_in = ~clock_in;

    // Reference model state
    int                m_div     [NUM_CH];
    int                m_shadow  [NUM_CH];
    int                m_elapsed [NUM_CH];
    logic [NUM_CH-1:0] m_out  = '0;
    logic [NUM_CH-1:0] m_tick = '0;
    logic [NUM_CH-1:0] m_pend = '0;
    logic              m_ack  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the model by one rising edge, using the inputs held across it.
    task automatic model_edge();
        logic sync_now;
        logic wr_ok;
        logic apply;
`ifdef MULTI_FREQ_DIVIDER_PHASE_SYNC_EN
        sync_now = sync_in;
`else
        sync_now = 1'b0;
`endif
        wr_ok = wr_en && (int'(wr_ch) < NUM_CH);
        if (!clear_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i]     = DEF_DIV;
                m_shadow[i]  = DEF_DIV;
                m_elapsed[i] = 0;
            end
            m_out  = '0;
            m_tick = '0;
            m_pend = '0;
            m_ack  = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (sync_now) begin
                    m_elapsed[i] = 0;
                    m_out[i]     = 1'b0;
                    m_tick[i]    = 1'b0;
                    apply        = 1'b1;
                end else if (ch_en[i]) begin
                    m_elapsed[i]++;
                    if (m_elapsed[i] == m_div[i] + 1) begin
                        m_elapsed[i] = 0;
                        m_out[i]     = ~m_out[i];
                        m_tick[i]    = 1'b1;
                        apply        = 1'b1;
                    end else begin
                        m_tick[i]    = 1'b0;
                        apply        = 1'b0;
                    end
                end else begin
                    m_elapsed[i] = 0;
                    m_tick[i]    = 1'b0;
                    apply        = 1'b1;
                end
                if (apply && m_pend[i]) begin
                    m_div[i]  = m_shadow[i];
                    m_pend[i] = 1'b0;
                end
                if (wr_ok && (int'(wr_ch) == i)) begin
                    m_shadow[i] = int'(wr_data);
                    m_pend[i]   = 1'b1;
                end
            end
            m_ack = wr_ok;
        end
    endtask

    // One clock edge: update the model, then sample the DUT 1 ns later.
    task automatic step();
        @(posedge clock_in);
        model_edge();
        #1;
        check_val("clock_out", 32'(clock_out), 32'(m_out));
        check_val("tick",      32'(tick),      32'(m_tick));
        check_val("pending",   32'(pending),   32'(m_pend));
        check_val("wr_ack",    32'(wr_ack),    32'(m_ack));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
        end
    endtask

    // Single-cycle write strobe.
    task automatic write_div(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] val);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = val;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        // Reset, then release with all channels enabled.
        clear_n = 1'b0;
        run(3);
        clear_n = 1'b1;
        ch_en   = 3'b111;
        run(10);

        // Mid-half-period divisor change on channel 1.
        run(1);
        write_div(2'd1, 8'd1);
        run(12);

        // Divide-by-one-edge on channel 0.
        write_div(2'd0, 8'd0);
        run(10);

        // Back-to-back writes (last wins), then an out-of-range channel.
        write_div(2'd0, 8'd5);
        write_div(2'd0, 8'd2);
        write_div(2'd3, 8'd7);
        run(12);

        // Pause channel 0 for three cycles.
        ch_en = 3'b110;
        run(3);
        ch_en = 3'b111;
        run(10);

        // Reset while a divisor is pending.
        write_div(2'd1, 8'd1);
        clear_n = 1'b0;
        run(1);
        clear_n = 1'b1;
        run(10);

`ifdef MULTI_FREQ_DIVIDER_PHASE_SYNC_EN
        // Phase realignment with a write captured in the same cycle.
        write_div(2'd0, 8'd1);
        run(3);
        sync_in = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd2;
        wr_data = 8'd2;
        step();
        sync_in = 1'b0;
        wr_en   = 1'b0;
        run(10);
`endif

        // Randomized soak.
        for (int k = 0; k < 600; k++) begin
            clear_n = ($urandom_range(0, 79) != 0);
            for (int c = 0; c < NUM_CH; c++) begin
                ch_en[c] = ($urandom_range(0, 9) != 0);
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = CH_W'($urandom_range(0, 3));
            wr_data = CNT_W'($urandom_range(0, 4));
`ifdef MULTI_FREQ_DIVIDER_PHASE_SYNC_EN
            sync_in = ($urandom_range(0, 29) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
